// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit.
package fwd_pkg;

  // Widest register address a stage tag can carry; REG_AW must not exceed it.
  localparam int unsigned TAG_AW_MAX = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EXE = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [TAG_AW_MAX-1:0] dst;
    logic                  reg_write;
    logic                  mem_read;
  } stage_tag_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // A stage produces a value for addr; register 0 never matches.
  function automatic logic tag_match(input stage_tag_t t, input logic [TAG_AW_MAX-1:0] addr);
    return t.valid & t.reg_write & (t.dst == addr) & (addr != {TAG_AW_MAX{1'b0}});
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Resolves one source operand against the EXE/MEM/WB tags (youngest wins).
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic [DATA_W-1:0] src_data_i,
  input  stage_tag_t        exe_tag_i,
  input  stage_tag_t        mem_tag_i,
  input  stage_tag_t        wb_tag_i,
  input  logic [DATA_W-1:0] exe_result_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output fwd_sel_e          sel_o,
  output logic [DATA_W-1:0] data_o,
  output logic              hazard_o
);

  logic [TAG_AW_MAX-1:0] src_ext_s;

  // Widen the source address to the tag address width.
  always_comb begin
    src_ext_s = {TAG_AW_MAX{1'b0}};
    src_ext_s[REG_AW-1:0] = src_addr_i;
  end

  // Priority match and data mux. A load that is still in EXE or MEM owns the
  // register: older stages hold stale values, so the regfile is shown and the
  // hazard bit is raised instead.
  always_comb begin
    sel_o    = FWD_RF;
    data_o   = src_data_i;
    hazard_o = 1'b0;
    if (tag_match(exe_tag_i, src_ext_s)) begin
      if (exe_tag_i.mem_read) begin
        hazard_o = 1'b1;
      end else begin
        sel_o  = FWD_EXE;
        data_o = exe_result_i;
      end
    end else if (tag_match(mem_tag_i, src_ext_s)) begin
      if (mem_tag_i.mem_read) begin
        hazard_o = 1'b1;
      end else begin
        sel_o  = FWD_MEM;
        data_o = mem_result_i;
      end
    end else if (tag_match(wb_tag_i, src_ext_s)) begin
      sel_o  = FWD_WB;
      data_o = wb_data_i;
    end else begin
      sel_o  = FWD_RF;
      data_o = src_data_i;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall unit with its own EXE/MEM/WB tag pipe.
// Optional build macro: FWD_STATS_EN adds stall_cycles / fwd_count counters.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]   id_src_data,
  input  logic [REG_AW-1:0]           id_dst_addr,
  input  logic                        id_reg_write,
  input  logic                        id_mem_read,
  input  logic [DATA_W-1:0]           exe_result,
  input  logic [DATA_W-1:0]           mem_result,
  input  logic [DATA_W-1:0]           wb_data,
  input  logic                        flush,
  output logic [NUM_SRC*DATA_W-1:0]   op_data,
  output logic [NUM_SRC*2-1:0]        fwd_sel,
  output logic                        stall,
  output logic                        stall_busy
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 fwd_count
`endif
);

  stage_tag_t exe_q, mem_q, wb_q;
  stage_tag_t exe_d;
  state_e     state_q;
  logic       stall_busy_q;

  fwd_sel_e          sel_s  [NUM_SRC];
  logic [DATA_W-1:0] data_s [NUM_SRC];
  logic [NUM_SRC-1:0] haz_s;
  logic              issue_s;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_operand_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_sel (
      .src_addr_i  (id_src_addr[g*REG_AW +: REG_AW]),
      .src_data_i  (id_src_data[g*DATA_W +: DATA_W]),
      .exe_tag_i   (exe_q),
      .mem_tag_i   (mem_q),
      .wb_tag_i    (wb_q),
      .exe_result_i(exe_result),
      .mem_result_i(mem_result),
      .wb_data_i   (wb_data),
      .sel_o       (sel_s[g]),
      .data_o      (data_s[g]),
      .hazard_o    (haz_s[g])
    );
  end

  // Pack per-operand results onto the flat output buses.
  always_comb begin
    op_data = {(NUM_SRC*DATA_W){1'b0}};
    fwd_sel = {(NUM_SRC*2){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      op_data[i*DATA_W +: DATA_W] = data_s[i];
      fwd_sel[i*2 +: 2]           = sel_s[i];
    end
  end

  // Load-use stall (a redirect kills the instruction, so flush wins) and the
  // next EXE tag: the ID instruction only when it really issues, else a bubble.
  always_comb begin
    stall   = id_valid & (|haz_s) & ~flush;
    issue_s = id_valid & ~stall & ~flush;
    exe_d   = '0;
    if (issue_s) begin
      exe_d.valid                = 1'b1;
      exe_d.dst[REG_AW-1:0]      = id_dst_addr;
      exe_d.reg_write            = id_reg_write;
      exe_d.mem_read             = id_mem_read;
    end else begin
      exe_d = '0;
    end
  end

  // Destination tag pipeline, advancing every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= exe_q;
      wb_q  <= mem_q;
    end
  end

  // RUN/STALL state machine with registered busy flag; flush forces RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      stall_busy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!flush && stall) begin
            state_q      <= ST_STALL;
            stall_busy_q <= 1'b1;
          end else begin
            state_q      <= ST_RUN;
            stall_busy_q <= 1'b0;
          end
        end
        ST_STALL: begin
          if (flush || !stall) begin
            state_q      <= ST_RUN;
            stall_busy_q <= 1'b0;
          end else begin
            state_q      <= ST_STALL;
            stall_busy_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_RUN;
          stall_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall_busy = stall_busy_q;

`ifdef FWD_STATS_EN
  logic [31:0] stall_cycles_q, fwd_count_q;
  logic [31:0] n_fwd_s;
  logic [32:0] fwd_sum_s;

  // Number of operands forwarded by an issuing instruction this cycle.
  always_comb begin
    n_fwd_s = 32'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_s[i] != FWD_RF) begin
        n_fwd_s = n_fwd_s + 32'd1;
      end else begin
        n_fwd_s = n_fwd_s;
      end
    end
    fwd_sum_s = {1'b0, fwd_count_q} + {1'b0, n_fwd_s};
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      fwd_count_q    <= 32'd0;
    end else begin
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end else begin
        stall_cycles_q <= stall_cycles_q;
      end
      if (issue_s) begin
        fwd_count_q <= fwd_sum_s[32] ? 32'hFFFF_FFFF : fwd_sum_s[31:0];
      end else begin
        fwd_count_q <= fwd_count_q;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_count    = fwd_count_q;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the 64-bit MIPS pipeline. It resolves every source operand of the instruction leaving ID against the in-flight destinations of EXE, MEM and WB, and selects register-file data or a forwarded result. It tracks those destinations in its own tag pipeline and stalls ID for load-use hazards. It replaces the single-operand, externally-selected three-way forwarding mux.

## Interface
Parameters:
- DATA_W, 64, operand/result width
- REG_AW, 5, register address width; address 0 is hard-wired zero
- NUM_SRC, 2, source operands resolved per instruction

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_src_addr  in  NUM_SRC*REG_AW  source register addresses, operand i at [i*REG_AW +: REG_AW]
- id_src_data  in  NUM_SRC*DATA_W  register-file read data
- id_dst_addr  in  REG_AW  ID destination register
- id_reg_write  in  1  ID instruction writes id_dst_addr
- id_mem_read  in  1  ID instruction is a load
- exe_result  in  DATA_W  ALU result currently in EXE
- mem_result  in  DATA_W  result held in EXE/MEM
- wb_data  in  DATA_W  write-back data, including load data
- flush  in  1  kill the ID instruction (branch/jump redirect)
- op_data  out  NUM_SRC*DATA_W  resolved operands
- fwd_sel  out  NUM_SRC*2  per-operand source: 0 regfile, 1 WB, 2 MEM, 3 EXE
- stall  out  1  hold PC and IF/ID; insert a bubble into EXE
- stall_busy  out  1  FSM is in STALL

## Operation
- Tag pipeline: three registered entries (EXE, MEM, WB). Each entry holds {valid, dst, reg_write, mem_read}.
- On every clock: WB<=MEM, MEM<=EXE. EXE<=ID fields when id_valid & !stall & !flush; otherwise EXE<=bubble (valid=0).
- Match for operand i at stage s: s.valid & s.reg_write & s.dst==src_i & src_i!=0.
- Priority is EXE > MEM > WB > regfile (youngest wins).
- EXE match with EXE.mem_read=0 gives sel 3, exe_result.
- MEM match with MEM.mem_read=0 gives sel 2, mem_result.
- WB match gives sel 1, wb_data.
- No match gives sel 0, id_src_data.
- Load-use hazard: id_valid & some operand matches EXE with EXE.mem_read=1, or matches MEM with MEM.mem_read=1. Load data is valid only at WB.
- stall = hazard & !flush. While stalled, op_data/fwd_sel still show the current best selection, but downstream must discard them.
- FSM states are RUN and STALL.
  - RUN->STALL when stall=1.
  - STALL->RUN when stall=0.
  - flush forces RUN.
  - stall_busy = (state==STALL).
- Outputs op_data, fwd_sel and stall are combinational from inputs and tags. Tags and state are registered.

## Timing
- Reset (asynchronous assert, synchronous release): all tags invalid, state RUN. Therefore stall=0, stall_busy=0, fwd_sel=0, op_data=id_src_data.
- Forwarding latency is zero cycles (combinational).
- Load immediately followed by a dependent instruction: stall for 2 cycles, then sel 1 on cycle 3.
- Load with one independent instruction in between: stall for 1 cycle, then sel 1.
- Simultaneous flush and hazard: flush wins. stall=0 and a bubble enters EXE.
- Reset mid-stall: tags clear and stall drops asynchronously.

## Configuration
- FWD_STATS_EN defined:
  - Adds outputs stall_cycles (32) and fwd_count (32), reset to 0, saturating at all-ones.
  - stall_cycles increments on every cycle with stall=1.
  - fwd_count adds the number of operands with fwd_sel!=0 on each cycle with id_valid & !stall & !flush.
- FWD_STATS_EN undefined: neither output exists and no counter logic is built.

## Structure
- Shared package fwd_pkg:
  - fwd_sel_e (FWD_RF=0, FWD_WB=1, FWD_MEM=2, FWD_EXE=3)
  - stage tag struct
  - state enum
- Sub-module fwd_operand_sel:
  - One instance per source, in a generate loop.
  - Contains match, priority and data mux; outputs that operand's sel, data and hazard bit.
  - The top level ORs the hazard bits.

## Test plan
- Reset with id_src_addr={3,4} and regfile data {0xA,0xB}: expect fwd_sel=0, op_data={0xA,0xB}, stall=0.
- Issue ADD r3 then SUB using r3, exe_result=0x55: expect sel 3, op_data[0]=0x55.
- Issue ADD r3, NOP, then a user of r3: expect sel 2 with mem_result. Two NOPs: expect sel 1 with wb_data.
- Issue LW r5 then a user of r5: expect stall=1 for 2 cycles and stall_busy set; then sel 1 with wb_data=0x1234.
- Issue LW r5 with flush asserted on the user: expect stall=0 and the next EXE tag to be a bubble.
- Issue a write to r0 then a user of r0: expect sel 0. Toggle rst_n low during a stall: expect stall=0 immediately.
